prepare_batch_eng_ctrl: RTL and testbench

// Control FSM for the VR replica prepare engine, batching variant. Accepts PREPARE messages from the

---
 rtl/prepare_batch_eng_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_prepare_batch_eng_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prepare_batch_eng_ctrl.sv
// Purpose: control FSM for the VR replica prepare engine that batches several PREPAREs into one PREPARE_OK.
// Latency: a message is accepted in the cycle it is offered while idle; its commit follows the later log done.
// Backpressure: the message is held off outside IDLE/BATCH_WAIT; PREPARE_OK valid/last hold until UDP ready.
module prepare_batch_eng_ctrl #(
    parameter int BATCH_MAX = 4,
    parameter int OK_FLITS  = 2,
    parameter int TIMER_W   = 16,
    parameter int BCNT_W    = $clog2(BATCH_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               manage_prep_msg_val,
    output logic               prep_manage_msg_rdy,
    input  logic               manage_prep_req_val,
    input  logic [BCNT_W-1:0]  cfg_batch_size,
    input  logic [TIMER_W-1:0] cfg_timeout,
    output logic               ctrl_datap_store_info,
    input  logic               datap_ctrl_flush_now,
    input  logic               datap_ctrl_log_has_space,
    output logic               start_req_ingest,
    input  logic               log_write_done,
    output logic               start_log_clean,
    input  logic               log_clean_done,
    output logic               prep_vr_state_wr_req,
    output logic               prep_to_udp_meta_val,
    input  logic               to_udp_prep_meta_rdy,
    output logic               prep_to_udp_data_val,
    output logic               prep_to_udp_data_last,
    input  logic               to_udp_prep_data_rdy,
    output logic               ctrl_datap_batch_clr,
    output logic [BCNT_W-1:0]  batch_count,
    output logic               prep_engine_rdy
);

    localparam int FLIT_W = (OK_FLITS > 1) ? $clog2(OK_FLITS) : 1;
    localparam logic [BCNT_W-1:0] BMAX_C    = BCNT_W'(BATCH_MAX);
    localparam logic [FLIT_W-1:0] LAST_FLIT = FLIT_W'(OK_FLITS - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ACCEPT     = 3'd1;
    localparam logic [2:0] S_WAIT_LOG   = 3'd2;
    localparam logic [2:0] S_DECIDE     = 3'd3;
    localparam logic [2:0] S_BATCH_WAIT = 3'd4;
    localparam logic [2:0] S_SEND_META  = 3'd5;
    localparam logic [2:0] S_SEND_DATA  = 3'd6;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [BCNT_W-1:0]  batch_cnt;
    logic [BCNT_W-1:0]  eff_size;
    logic [TIMER_W-1:0] timer;
    logic [FLIT_W-1:0]  flit_cnt;
    logic               wr_seen;
    logic               clean_seen;

    logic in_wait;
    logic timeout_hit;
    logic take_msg;
    logic commit;
    logic flush;
    logic last_flit;
    logic ok_done;

    // Timeout is only acted on while a batch is open (BATCH_WAIT / DECIDE).
    assign in_wait     = (state == S_IDLE) || (state == S_BATCH_WAIT);
    assign timeout_hit = (timer >= cfg_timeout);
    // A due timeout beats a same-cycle message: the message stays pending for the next batch.
    assign take_msg    = in_wait && manage_prep_msg_val && manage_prep_req_val &&
                         !((state == S_BATCH_WAIT) && timeout_hit);
    // Same-cycle done inputs count together with the sticky copies.
    assign commit      = (state == S_WAIT_LOG) &&
                         (wr_seen || log_write_done) && (clean_seen || log_clean_done);
    assign flush       = (batch_cnt >= eff_size) || datap_ctrl_flush_now ||
                         !datap_ctrl_log_has_space || timeout_hit;
    assign last_flit   = (flit_cnt == LAST_FLIT);
    assign ok_done     = (state == S_SEND_DATA) && to_udp_prep_data_rdy && last_flit;

    assign prep_manage_msg_rdy   = take_msg;
    assign start_req_ingest      = take_msg;
    assign start_log_clean       = take_msg;
    assign ctrl_datap_store_info = in_wait;
    assign prep_engine_rdy       = in_wait;
    assign prep_vr_state_wr_req  = commit;
    assign prep_to_udp_meta_val  = (state == S_SEND_META);
    assign prep_to_udp_data_val  = (state == S_SEND_DATA);
    assign prep_to_udp_data_last = (state == S_SEND_DATA) && last_flit;
    assign ctrl_datap_batch_clr  = ok_done;
    assign batch_count           = batch_cnt;

    // Clamp the configured batch size into 1..BATCH_MAX.
    always_comb begin
        eff_size = cfg_batch_size;
        if (cfg_batch_size == '0) begin
            eff_size = BCNT_W'(1);
        end else if (cfg_batch_size > BMAX_C) begin
            eff_size = BMAX_C;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take_msg) state_nxt = S_ACCEPT;
            end
            S_BATCH_WAIT: begin
                if (timeout_hit)   state_nxt = S_SEND_META;
                else if (take_msg) state_nxt = S_ACCEPT;
            end
            S_ACCEPT:   state_nxt = S_WAIT_LOG;
            S_WAIT_LOG: begin
                if (commit) state_nxt = S_DECIDE;
            end
            S_DECIDE:   state_nxt = flush ? S_SEND_META : S_BATCH_WAIT;
            S_SEND_META: begin
                if (to_udp_prep_meta_rdy) state_nxt = S_SEND_DATA;
            end
            S_SEND_DATA: begin
                if (ok_done) state_nxt = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Prepares in the open batch: bumped on each commit, cleared when the PREPARE_OK completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batch_cnt <= '0;
        end else if (ok_done) begin
            batch_cnt <= '0;
        end else if (commit && (batch_cnt < BMAX_C)) begin
            batch_cnt <= batch_cnt + BCNT_W'(1);
        end
    end

    // Batch age: starts at the first accept, runs while a prepare is in flight or batched, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (ok_done) begin
            timer <= '0;
        end else if (take_msg && (batch_cnt == '0)) begin
            timer <= '0;
        end else if (((batch_cnt != '0) || (state == S_ACCEPT) || (state == S_WAIT_LOG)) &&
                     (timer != {TIMER_W{1'b1}})) begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // Flit index within the PREPARE_OK payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt <= '0;
        end else if (state == S_SEND_META) begin
            flit_cnt <= '0;
        end else if ((state == S_SEND_DATA) && to_udp_prep_data_rdy) begin
            flit_cnt <= last_flit ? '0 : flit_cnt + FLIT_W'(1);
        end
    end

    // Sticky log-engine completions so pulse and level dones both work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_seen    <= 1'b0;
            clean_seen <= 1'b0;
        end else if (state == S_ACCEPT) begin
            wr_seen    <= 1'b0;
            clean_seen <= 1'b0;
        end else if (state == S_WAIT_LOG) begin
            wr_seen    <= wr_seen || log_write_done;
            clean_seen <= clean_seen || log_clean_done;
        end
    end

endmodule

// File: tb/tb_prepare_batch_eng_ctrl.sv
// Bench for prepare_batch_eng_ctrl: a timeline model of each batch predicts every output per cycle.
// Stimulus is randomized per batch; directed batches pin latencies and counts with literal values.
// All waits are driven by the bench's own schedule, so the run always terminates.
module tb_prepare_batch_eng_ctrl;
    localparam int BM = 4;
    localparam int OF = 3;
    localparam int TW = 16;
    localparam int BW = $clog2(BM + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          manage_prep_msg_val, manage_prep_req_val;
    logic          prep_manage_msg_rdy;
    logic [BW-1:0] cfg_batch_size;
    logic [TW-1:0] cfg_timeout;
    logic          ctrl_datap_store_info, datap_ctrl_flush_now, datap_ctrl_log_has_space;
    logic          start_req_ingest, log_write_done, start_log_clean, log_clean_done;
    logic          prep_vr_state_wr_req, prep_to_udp_meta_val, to_udp_prep_meta_rdy;
    logic          prep_to_udp_data_val, prep_to_udp_data_last, to_udp_prep_data_rdy;
    logic          ctrl_datap_batch_clr, prep_engine_rdy;
    logic [BW-1:0] batch_count;

    always #5 clk = ~clk;

    prepare_batch_eng_ctrl #(.BATCH_MAX(BM), .OK_FLITS(OF), .TIMER_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .manage_prep_msg_val(manage_prep_msg_val), .prep_manage_msg_rdy(prep_manage_msg_rdy),
        .manage_prep_req_val(manage_prep_req_val),
        .cfg_batch_size(cfg_batch_size), .cfg_timeout(cfg_timeout),
        .ctrl_datap_store_info(ctrl_datap_store_info),
        .datap_ctrl_flush_now(datap_ctrl_flush_now), .datap_ctrl_log_has_space(datap_ctrl_log_has_space),
        .start_req_ingest(start_req_ingest), .log_write_done(log_write_done),
        .start_log_clean(start_log_clean), .log_clean_done(log_clean_done),
        .prep_vr_state_wr_req(prep_vr_state_wr_req),
        .prep_to_udp_meta_val(prep_to_udp_meta_val), .to_udp_prep_meta_rdy(to_udp_prep_meta_rdy),
        .prep_to_udp_data_val(prep_to_udp_data_val), .prep_to_udp_data_last(prep_to_udp_data_last),
        .to_udp_prep_data_rdy(to_udp_prep_data_rdy),
        .ctrl_datap_batch_clr(ctrl_datap_batch_clr), .batch_count(batch_count),
        .prep_engine_rdy(prep_engine_rdy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;

    // expected outputs for the current cycle
    bit e_rdy, e_start, e_store, e_eng, e_wr, e_meta, e_data, e_last, e_clr;
    int e_cnt;

    // model state
    int cfg_sz_i, cfg_to_i;
    int m_cnt = 0;
    int m_first = 0;

    // per-batch stimulus knobs
    int g_gap_max, g_dmax, g_fl_at, g_nsp_at, g_meta_stall, g_rdy_pct, g_nmsg, g_rst_flit, g_wfix, g_cfix;

    // observed events
    int n_wr, n_clr, n_ok, meta_cycles, wr_cyc, clr_cyc, meta_start, first_acc, cnt_at_clr;
    bit prev_meta = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input int ex);
        n_chk++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, ex);
        end
    endtask

    // Every output checked each cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("msg_rdy", prep_manage_msg_rdy, e_rdy);
            cmp("start_req_ingest", start_req_ingest, e_start);
            cmp("start_log_clean", start_log_clean, e_start);
            cmp("store_info", ctrl_datap_store_info, e_store);
            cmp("engine_rdy", prep_engine_rdy, e_eng);
            cmp("vr_state_wr_req", prep_vr_state_wr_req, e_wr);
            cmp("meta_val", prep_to_udp_meta_val, e_meta);
            cmp("data_val", prep_to_udp_data_val, e_data);
            cmp("data_last", prep_to_udp_data_last, e_last);
            cmp("batch_clr", ctrl_datap_batch_clr, e_clr);
            cmp("batch_count", batch_count, e_cnt);
            if (prep_manage_msg_rdy && batch_count == 0) first_acc = cyc;
            if (prep_vr_state_wr_req) begin n_wr++; wr_cyc = cyc; end
            if (prep_to_udp_meta_val) begin
                meta_cycles++;
                if (!prev_meta) begin n_ok++; meta_start = cyc; end
            end
            prev_meta = prep_to_udp_meta_val;
            if (ctrl_datap_batch_clr) begin n_clr++; clr_cyc = cyc; cnt_at_clr = batch_count; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int eff();
        if (cfg_sz_i == 0) return 1;
        if (cfg_sz_i > BM) return BM;
        return cfg_sz_i;
    endfunction

    // Batch age in the current cycle: zero the cycle after the first accept, +1 per cycle.
    function automatic int tmr();
        int t;
        t = cyc - m_first - 1;
        return (t > 65535) ? 65535 : t;
    endfunction

    function automatic bit rnd(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic exp_clear();
        e_rdy = 0; e_start = 0; e_store = 0; e_eng = 0; e_wr = 0;
        e_meta = 0; e_data = 0; e_last = 0; e_clr = 0; e_cnt = m_cnt;
    endtask

    task automatic noise();
        manage_prep_msg_val      = $urandom_range(0, 1);
        manage_prep_req_val      = $urandom_range(0, 1);
        datap_ctrl_flush_now     = $urandom_range(0, 1);
        datap_ctrl_log_has_space = $urandom_range(0, 1);
        log_write_done           = $urandom_range(0, 1);
        log_clean_done           = $urandom_range(0, 1);
        to_udp_prep_meta_rdy     = $urandom_range(0, 1);
        to_udp_prep_data_rdy     = $urandom_range(0, 1);
    endtask

    task automatic reset_obs();
        n_wr = 0; n_clr = 0; n_ok = 0; meta_cycles = 0;
        wr_cyc = -1; clr_cyc = -1; meta_start = -1; first_acc = -1; cnt_at_clr = -1;
    endtask

    // One PREPARE_OK: metadata beat then OF data flits, optionally cut by a reset mid-payload.
    task automatic send_ok();
        int st;
        int f;
        bit r;
        bit fin;
        st = 0; f = 0; fin = 0;
        while (!fin) begin
            noise();
            r = (g_meta_stall > 0) ? (st >= g_meta_stall) : (rnd(g_rdy_pct) || st >= 100);
            to_udp_prep_meta_rdy = r;
            exp_clear(); e_meta = 1;
            tick();
            st++;
            if (r) fin = 1;
        end
        fin = 0; st = 0;
        while (!fin) begin
            noise();
            if (f == g_rst_flit) begin
                manage_prep_msg_val = 0; manage_prep_req_val = 0;
                rst_n = 0;
                m_cnt = 0;
                exp_clear(); e_store = 1; e_eng = 1;
                tick();
                manage_prep_msg_val = 0; manage_prep_req_val = 0;
                tick();
                rst_n = 1;
                fin = 1;
            end else begin
                r = rnd(g_rdy_pct) || st >= 100;
                to_udp_prep_data_rdy = r;
                exp_clear(); e_data = 1; e_last = (f == OF - 1); e_clr = r && (f == OF - 1);
                tick();
                st++;
                if (r) begin
                    if (f == OF - 1) begin m_cnt = 0; fin = 1; end
                    else f++;
                end
            end
        end
    endtask

    // One complete batch, from the first offered message to the end of its PREPARE_OK.
    task automatic do_batch();
        int k, gap, w, c, cm;
        bit done, acc, to_hit, fl, sp, lvl, fl_d;
        k = 0; done = 0;
        cfg_batch_size = cfg_sz_i[BW-1:0];
        cfg_timeout    = cfg_to_i[TW-1:0];
        while (!done) begin
            gap = $urandom_range(0, g_gap_max);
            acc = 0; to_hit = 0;
            while (!acc && !to_hit) begin
                noise();
                exp_clear(); e_store = 1; e_eng = 1;
                if (k < g_nmsg && gap == 0) begin
                    manage_prep_msg_val = 1; manage_prep_req_val = 1;
                end else begin
                    manage_prep_req_val = manage_prep_msg_val ? 1'b0 : manage_prep_req_val;
                end
                if (m_cnt > 0 && tmr() >= cfg_to_i) begin
                    to_hit = 1;
                end else if (manage_prep_msg_val && manage_prep_req_val) begin
                    acc = 1; e_rdy = 1; e_start = 1;
                    if (m_cnt == 0) m_first = cyc;
                end
                tick();
                if (gap > 0) gap--;
            end
            if (to_hit) begin
                send_ok();
                done = 1;
            end else begin
                fl = (k == g_fl_at) || (g_fl_at == -2 && $urandom_range(0, 7) == 0);
                sp = !((k == g_nsp_at) || (g_nsp_at == -2 && $urandom_range(0, 7) == 0));
                noise();
                log_write_done = 0; log_clean_done = 0;
                datap_ctrl_flush_now = fl; datap_ctrl_log_has_space = sp;
                exp_clear();
                tick();
                w  = (g_wfix >= 0) ? g_wfix : $urandom_range(0, g_dmax);
                c  = (g_cfix >= 0) ? g_cfix : $urandom_range(0, g_dmax);
                cm = (w > c) ? w : c;
                lvl = $urandom_range(0, 1);
                for (int i = 0; i <= cm; i++) begin
                    noise();
                    datap_ctrl_flush_now = fl; datap_ctrl_log_has_space = sp;
                    log_write_done = (i == w) || (lvl && i > w);
                    log_clean_done = (i == c) || (lvl && i > c);
                    exp_clear(); e_wr = (i == cm);
                    tick();
                end
                m_cnt++; k++;
                noise();
                datap_ctrl_flush_now = fl; datap_ctrl_log_has_space = sp;
                exp_clear();
                fl_d = (m_cnt >= eff()) || fl || !sp || (tmr() >= cfg_to_i);
                tick();
                if (fl_d) begin
                    send_ok();
                    done = 1;
                end
            end
        end
    endtask

    task automatic knobs(input int sz, input int to, input int nmsg, input int gap, input int dmax);
        cfg_sz_i = sz; cfg_to_i = to; g_nmsg = nmsg; g_gap_max = gap; g_dmax = dmax;
        g_fl_at = -1; g_nsp_at = -1; g_meta_stall = 0; g_rdy_pct = 100;
        g_rst_flit = -1; g_wfix = -1; g_cfix = -1;
    endtask

    initial begin
        rst_n = 1;
        manage_prep_msg_val = 0; manage_prep_req_val = 0;
        datap_ctrl_flush_now = 0; datap_ctrl_log_has_space = 1;
        log_write_done = 0; log_clean_done = 0;
        to_udp_prep_meta_rdy = 0; to_udp_prep_data_rdy = 0;
        cfg_batch_size = 1; cfg_timeout = 0;
        reset_obs();
        #2;
        rst_n = 0;
        exp_clear(); e_store = 1; e_eng = 1;
        chk_en = 1;
        tick();
        tick();
        rst_n = 1;

        // single prepare, no batching, same-cycle dones
        knobs(1, 0, 1, 0, 0); g_wfix = 0; g_cfix = 0;
        reset_obs(); do_batch();
        cmp("t1_wr_latency", wr_cyc - first_acc, 2);
        cmp("t1_meta_latency", meta_start - first_acc, 4);
        cmp("t1_clr_latency", clr_cyc - first_acc, 7);
        cmp("t1_ok_count", n_ok, 1);

        // four back-to-back prepares close on count
        knobs(4, 1000, 4, 0, 3);
        reset_obs(); do_batch();
        cmp("t2_wr_pulses", n_wr, 4);
        cmp("t2_ok_count", n_ok, 1);
        cmp("t2_clr_count", n_clr, 1);
        cmp("t2_count_at_clr", cnt_at_clr, 4);

        // two prepares then idle: timeout closes the batch
        knobs(4, 20, 2, 0, 2);
        reset_obs(); do_batch();
        cmp("t3_meta_at_timeout", meta_start - first_acc, 22);
        cmp("t3_count_at_clr", cnt_at_clr, 2);

        // clean done five cycles after write done
        knobs(4, 1000, 1, 0, 0); g_wfix = 0; g_cfix = 5; g_fl_at = 0;
        reset_obs(); do_batch();
        cmp("t4_wr_latency", wr_cyc - first_acc, 7);
        cmp("t4_wr_pulses", n_wr, 1);

        // flush_now on second prepare, UDP meta stalled for 10 cycles
        knobs(4, 1000, 4, 2, 3); g_fl_at = 1; g_meta_stall = 10;
        reset_obs(); do_batch();
        cmp("t5_wr_pulses", n_wr, 2);
        cmp("t5_meta_hold", meta_cycles, 11);
        cmp("t5_count_at_clr", cnt_at_clr, 2);

        // reset in the middle of the payload with toggling data ready
        knobs(1, 0, 1, 1, 2); g_rdy_pct = 50; g_rst_flit = 1;
        reset_obs(); do_batch();
        cmp("t6_no_clr", n_clr, 0);
        cmp("t6_ok_started", n_ok, 1);
        knobs(2, 0, 1, 1, 2);
        reset_obs(); do_batch();
        cmp("t6_recovered_clr", n_clr, 1);

        // randomized batches
        for (int b = 0; b < 40; b++) begin
            int sel;
            int to;
            sel = $urandom_range(0, 3);
            to = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 40) : (sel == 2) ? 1000 : $urandom_range(5, 15);
            knobs($urandom_range(0, 7), to, (sel == 2) ? BM + 1 : $urandom_range(1, 6),
                  3, 4);
            g_fl_at = -2; g_nsp_at = -2; g_rdy_pct = 60;
            do_batch();
        end

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
